// File: rtl/sram_pkg.sv
// sram_pkg: shared types and widths for the Wishbone-to-async-SRAM responder.
package sram_pkg;
  localparam int SRAM_AW = 19;
  localparam int SRAM_DW = 16;
  localparam int CNT_W   = 4;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;
endpackage

// File: rtl/sram_wbs.sv
// sram_wbs: Wishbone B4 pipelined responder driving a 512K x 16 asynchronous SRAM.
module sram_wbs
  import sram_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic               clk_i,
  input  logic               _reset_i,
  input  logic               cyc_i,
  input  logic               stb_i,
  input  logic               we_i,
  input  logic [1:0]         sel_i,
  input  logic [SRAM_AW-1:0] adr_i,
  input  logic [SRAM_DW-1:0] dat_i,
  output logic               ack_o,
  output logic [SRAM_DW-1:0] dat_o,
  output logic               stall_o,
  output logic               _sram_ce,
  output logic               _sram_we,
  output logic               _sram_oe,
  output logic               _sram_ub,
  output logic               _sram_lb,
  output logic [SRAM_AW-1:0] sram_a,
  output logic [SRAM_DW-1:0] sram_d_out,
  output logic               sram_d_oe,
  input  logic [SRAM_DW-1:0] sram_d_in
);
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               abort_q, abort_d;
  logic [SRAM_DW-1:0] dat_q, dat_d;
  logic [SRAM_AW-1:0] a_q, a_d;
  logic [SRAM_DW-1:0] dout_q, dout_d;
  logic               doe_q, doe_d;
  logic               ce_q, ce_d, we_q, we_d, oe_q, oe_d, ub_q, ub_d, lb_q, lb_d;
  logic               accept;
  assign stall_o = state_q == ACCESS;
  assign accept  = cyc_i & stb_i & ~stall_o;
  assign ack_o   = (state_q == DONE) & ~abort_q & cyc_i;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    abort_d = abort_q;
    dat_d   = dat_q;
    a_d     = a_q;
    dout_d  = dout_q;
    doe_d   = doe_q;
    ce_d    = ce_q;
    we_d    = we_q;
    oe_d    = oe_q;
    ub_d    = ub_q;
    lb_d    = lb_q;
    if (accept) begin
      state_d = ACCESS;
      cnt_d   = CNT_W'(WAIT_STATES);
      abort_d = 1'b0;
      a_d     = adr_i;
      dout_d  = dat_i;
      ub_d    = ~sel_i[1];
      lb_d    = ~sel_i[0];
      ce_d    = 1'b0;
      we_d    = ~we_i;
      oe_d    = we_i;
      doe_d   = we_i;
    end else if (state_q == ACCESS) begin
      abort_d = abort_q | ~cyc_i;
      cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
      if (cnt_q == '0) begin
        state_d = DONE;
        dat_d   = oe_q ? dat_q : sram_d_in;
        we_d    = 1'b1;
        oe_d    = 1'b1;
      end
    end else if (state_q == DONE) begin
      // CE, address and write data were held through DONE for hold time
      state_d = IDLE;
      ce_d    = 1'b1;
      doe_d   = 1'b0;
      ub_d    = 1'b1;
      lb_d    = 1'b1;
    end
  end
  always_ff @(posedge clk_i or negedge _reset_i) begin
    if (!_reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      abort_q <= 1'b0;
      dat_q   <= '0;
      a_q     <= '0;
      dout_q  <= '0;
      doe_q   <= 1'b0;
      ce_q    <= 1'b1;
      we_q    <= 1'b1;
      oe_q    <= 1'b1;
      ub_q    <= 1'b1;
      lb_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
      dat_q   <= dat_d;
      a_q     <= a_d;
      dout_q  <= dout_d;
      doe_q   <= doe_d;
      ce_q    <= ce_d;
      we_q    <= we_d;
      oe_q    <= oe_d;
      ub_q    <= ub_d;
      lb_q    <= lb_d;
    end
  end
  assign dat_o      = dat_q;
  assign sram_a     = a_q;
  assign sram_d_out = dout_q;
  assign sram_d_oe  = doe_q;
  assign _sram_ce   = ce_q;
  assign _sram_we   = we_q;
  assign _sram_oe   = oe_q;
  assign _sram_ub   = ub_q;
  assign _sram_lb   = lb_q;
endmodule
